pc_gen: RTL and testbench

//  Parametrised program-counter generator for the pipelined core; replaces the single-cycle PC register.

---
 rtl/pc_gen.sv | 163 ++++++++++++++++
 tb/tb_pc_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/eret/branch/jump redirect and EPC; redirect history under PC_HIST_EN.
// Latency: one cycle from any input to pc_o/epc_o/misalign_o; hist_pc_o is a combinational read of history.
// Backpressure: pc_o holds while fetch_ready_i=0 or stall_i=1; redirects override both and are never held off.
module pc_gen #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h80,
    parameter int unsigned       HIST_DEPTH   = 8,
    localparam int unsigned      HIST_W       = $clog2(HIST_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [XLEN-1:0]   br_target_i,
    input  logic              jmp_i,
    input  logic [XLEN-1:0]   jmp_target_i,
    input  logic              trap_i,
    input  logic              eret_i,
    input  logic              fetch_ready_i,
    output logic              fetch_valid_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   epc_o,
    output logic              misalign_o,
    input  logic [HIST_W-1:0] hist_idx_i,
    output logic [XLEN-1:0]   hist_pc_o
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              run;

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   epc_d;
    logic              misalign_q;
    logic              misalign_d;
    logic [XLEN-1:0]   tgt;
    logic              redir;
    logic              advance;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run           = (state_q == ST_RUN);
        fetch_valid_o = run;
    end

    assign advance = fetch_valid_o & fetch_ready_i & ~stall_i;

    // Shared target mux for the non-trap redirects, in priority order eret > branch > jump.
    always_comb begin
        tgt = jmp_target_i;
        if (br_taken_i) begin
            tgt = br_target_i;
        end
        if (eret_i) begin
            tgt = epc_q;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        redir      = 1'b0;
        if (run) begin
            if (trap_i) begin
                redir = 1'b1;
                pc_d  = TRAP_VECTOR;
                epc_d = pc_q;
            end else if (eret_i || br_taken_i || jmp_i) begin
                redir = 1'b1;
                // A misaligned target is turned into a trap that records the bad target.
                if (tgt[1:0] != 2'b00) begin
                    pc_d       = TRAP_VECTOR;
                    epc_d      = tgt;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = tgt;
                end
            end else if (advance) begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign epc_o      = epc_q;
    assign misalign_o = misalign_q;

`ifdef PC_HIST_EN
    logic [XLEN-1:0]   hist_q [HIST_DEPTH];
    logic [XLEN-1:0]   hist_d [HIST_DEPTH];
    logic [HIST_W-1:0] wptr_q;
    logic [HIST_W-1:0] wptr_d;
    logic [HIST_W-1:0] rd_idx;

    always_comb begin
        hist_d = hist_q;
        wptr_d = wptr_q;
        if (redir) begin
            hist_d[wptr_q] = pc_q;
            wptr_d         = wptr_q + HIST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '{default: '0};
            wptr_q <= '0;
        end else begin
            hist_q <= hist_d;
            wptr_q <= wptr_d;
        end
    end

    // Index 0 is the most recent write; modulo wrap comes from the power-of-2 depth.
    assign rd_idx    = wptr_q - HIST_W'(1) - hist_idx_i;
    assign hist_pc_o = hist_q[rd_idx];
`else
    logic unused_hist;
    assign unused_hist = redir ^ (^hist_idx_i);
    assign hist_pc_o   = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, history sequence, and randomized run against a queue-based model.
module tb_pc_gen;

    localparam int HD = 8;
    localparam logic [31:0] RV = 32'h0;
    localparam logic [31:0] TV = 32'h80;

    logic        clk = 1'b0;
    logic        rst, stall_i, br_taken_i, jmp_i, trap_i, eret_i, fetch_ready_i;
    logic [31:0] br_target_i, jmp_target_i;
    logic        fetch_valid_o, misalign_o;
    logic [31:0] pc_o, epc_o, hist_pc_o;
    logic [2:0]  hist_idx_i;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .trap_i       (trap_i),
        .eret_i       (eret_i),
        .fetch_ready_i(fetch_ready_i),
        .fetch_valid_o(fetch_valid_o),
        .pc_o         (pc_o),
        .epc_o        (epc_o),
        .misalign_o   (misalign_o),
        .hist_idx_i   (hist_idx_i),
        .hist_pc_o    (hist_pc_o)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state plus history as a newest-first queue.
    logic        m_boot;
    logic [31:0] m_pc, m_epc;
    logic        m_mis;
    logic [31:0] m_hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic hist_push(input logic [31:0] v);
        m_hist.push_front(v);
        void'(m_hist.pop_back());
    endtask

    task automatic model_step();
        logic [31:0] t;
        if (rst) begin
            m_boot = 1'b1;
            m_pc   = RV;
            m_epc  = 32'h0;
            m_mis  = 1'b0;
            m_hist = {};
            for (int i = 0; i < HD; i++) m_hist.push_back(32'h0);
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_mis  = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (trap_i) begin
                hist_push(m_pc);
                m_epc = m_pc;
                m_pc  = TV;
            end else if (eret_i || br_taken_i || jmp_i) begin
                t = eret_i ? m_epc : (br_taken_i ? br_target_i : jmp_target_i);
                hist_push(m_pc);
                if ((t % 4) != 0) begin
                    m_epc = t;
                    m_pc  = TV;
                    m_mis = 1'b1;
                end else begin
                    m_pc = t;
                end
            end else if (fetch_ready_i && !stall_i) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    function automatic logic [31:0] m_hist_rd(input logic [2:0] idx);
`ifdef PC_HIST_EN
        return m_hist[idx];
`else
        return (idx == idx) ? 32'h0 : 32'h0;
`endif
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_pc",   pc_o,                  m_pc);
        chk("model_epc",  epc_o,                 m_epc);
        chk("model_vld",  {31'h0, fetch_valid_o}, {31'h0, ~m_boot});
        chk("model_mis",  {31'h0, misalign_o},    {31'h0, m_mis});
        chk("model_hist", hist_pc_o,             m_hist_rd(hist_idx_i));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall_i = 1'b0; fetch_ready_i = 1'b0;
        trap_i = 1'b0; eret_i = 1'b0; br_taken_i = 1'b0; jmp_i = 1'b0;
        br_target_i = 32'h0; jmp_target_i = 32'h0;
    endtask

    typedef struct {
        logic        rst, stall, rdy, trap, eret, br, jmp;
        logic [31:0] brt, jt;
        logic [31:0] e_pc, e_epc;
        logic        e_vld, e_mis;
    } vec_t;

    vec_t vec[24];

    initial begin
        //         rst stl rdy trp ert br  jmp brt            jt             pc             epc            vld mis
        vec[0]  = '{1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h0,         32'h0,         0,  0};
        vec[1]  = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h0,         32'h0,         1,  0};
        vec[2]  = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h4,         32'h0,         1,  0};
        vec[3]  = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h8,         32'h0,         1,  0};
        vec[4]  = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'hC,         32'h0,         1,  0};
        vec[5]  = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h10,        32'h0,         1,  0};
        vec[6]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h10,        32'h0,         1,  0};
        vec[7]  = '{0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h10,        32'h0,         1,  0};
        vec[8]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h10,        32'h0,         1,  0};
        vec[9]  = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h14,        32'h0,         1,  0};
        vec[10] = '{0, 0, 1, 0, 0, 0, 1, 32'h0,        32'h20,        32'h20,        32'h0,         1,  0};
        vec[11] = '{0, 0, 1, 1, 0, 1, 0, 32'h100,      32'h0,         32'h80,        32'h20,        1,  0};
        vec[12] = '{0, 0, 1, 0, 1, 0, 0, 32'h0,        32'h0,         32'h20,        32'h20,        1,  0};
        vec[13] = '{0, 0, 1, 0, 0, 1, 0, 32'h102,      32'h0,         32'h80,        32'h102,       1,  1};
        vec[14] = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h84,        32'h102,       1,  0};
        vec[15] = '{0, 1, 1, 0, 0, 0, 1, 32'h0,        32'hFFFFFFFC,  32'hFFFFFFFC,  32'h102,       1,  0};
        vec[16] = '{0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h0,         32'h102,       1,  0};
        vec[17] = '{1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h0,         32'h0,         0,  0};
        vec[18] = '{0, 0, 1, 1, 0, 0, 1, 32'h0,        32'h40,        32'h0,         32'h0,         1,  0};
        vec[19] = '{0, 0, 1, 0, 0, 1, 1, 32'h1,        32'h40,        32'h80,        32'h1,         1,  1};
        vec[20] = '{0, 0, 1, 0, 1, 0, 0, 32'h0,        32'h0,         32'h80,        32'h1,         1,  1};
        vec[21] = '{0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h44,        32'h44,        32'h1,         1,  0};
        vec[22] = '{0, 0, 1, 1, 1, 0, 0, 32'h0,        32'h0,         32'h80,        32'h44,        1,  0};
        vec[23] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h80,        32'h44,        1,  0};

        idle_inputs();
        hist_idx_i = 3'd0;

        // Directed table
        for (int i = 0; i < 24; i++) begin
            rst = vec[i].rst; stall_i = vec[i].stall; fetch_ready_i = vec[i].rdy;
            trap_i = vec[i].trap; eret_i = vec[i].eret;
            br_taken_i = vec[i].br; br_target_i = vec[i].brt;
            jmp_i = vec[i].jmp; jmp_target_i = vec[i].jt;
            tick();
            chk($sformatf("vec%0d_pc", i),  pc_o,  vec[i].e_pc);
            chk($sformatf("vec%0d_epc", i), epc_o, vec[i].e_epc);
            chk($sformatf("vec%0d_vld", i), {31'h0, fetch_valid_o}, {31'h0, vec[i].e_vld});
            chk($sformatf("vec%0d_mis", i), {31'h0, misalign_o},    {31'h0, vec[i].e_mis});
        end

        // History sequence: jumps from 0x4, 0x8, 0xC, ... nine redirects into depth 8
        idle_inputs();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        fetch_ready_i = 1'b1; tick();
        chk("hseq_start_pc", pc_o, 32'h4);
        for (int k = 0; k < 9; k++) begin
            jmp_i = 1'b1;
            jmp_target_i = 32'h8 + 32'(4 * k);
            tick();
            if (k == 2) begin
`ifdef PC_HIST_EN
                hist_idx_i = 3'd0; #1; chk("hist_idx0_after3", hist_pc_o, 32'hC);
                hist_idx_i = 3'd2; #1; chk("hist_idx2_after3", hist_pc_o, 32'h4);
`else
                hist_idx_i = 3'd2; #1; chk("hist_tied0", hist_pc_o, 32'h0);
`endif
                hist_idx_i = 3'd0;
            end
        end
        jmp_i = 1'b0; fetch_ready_i = 1'b0;
        chk("hseq_end_pc", pc_o, 32'h28);
`ifdef PC_HIST_EN
        hist_idx_i = 3'd0; #1; chk("hist_idx0_after9", hist_pc_o, 32'h24);
        hist_idx_i = 3'd7; #1; chk("hist_idx7_after9", hist_pc_o, 32'h8);
`else
        hist_idx_i = 3'd7; #1; chk("hist_tied0_b", hist_pc_o, 32'h0);
`endif
        hist_idx_i = 3'd0;

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(63) == 0);
            stall_i       = ($urandom_range(3) == 0);
            fetch_ready_i = ($urandom_range(3) != 0);
            trap_i        = ($urandom_range(15) == 0);
            eret_i        = ($urandom_range(15) == 0);
            br_taken_i    = ($urandom_range(7) == 0);
            jmp_i         = ($urandom_range(7) == 0);
            br_target_i   = {$urandom() & 32'hFFFFFFFC} | (($urandom_range(3) == 0) ? 32'($urandom_range(3)) : 32'h0);
            jmp_target_i  = {$urandom() & 32'hFFFFFFFC} | (($urandom_range(3) == 0) ? 32'($urandom_range(3)) : 32'h0);
            hist_idx_i    = 3'($urandom_range(7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
